rx_bit_sampler: RTL

- Front end of the UART receive path; sits directly upstream of the Rx framing state machine.
- Synchronises the raw rx line and oversamples it at the 16x baud acquisition tick.
- Majority-votes three centre samples per bit and produces the two strobes the framing FSM needs:
  - mid-bit synch strobe (frame start and data-bit counting);
  - per-bit completion strobe.
- Also reports the voted bit value, false starts and stop-bit framing errors.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/rx_line_sync.sv | 21 ++
 rtl/rx_bit_sampler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receive-path definitions: one-hot Rx state encodings used by the
// framing FSM and the bit sampler, plus common defaults.
package uart_rx_pkg;

  localparam int   OVERSAMPLE_DEF = 16;
  localparam logic ENABLE         = 1'b1;
  localparam logic DISABLE        = 1'b0;

  // Framing FSM states; the sampler mirrors the same one-hot code points.
  typedef enum logic [4:0] {
    INTERVAL  = 5'b00001,
    STARTBIT  = 5'b00010,
    DATABITS  = 5'b00100,
    PARITYBIT = 5'b01000,
    STOPBIT   = 5'b10000
  } rx_state_t;

  typedef enum logic [4:0] {
    SMP_IDLE   = 5'b00001,
    SMP_START  = 5'b00010,
    SMP_DATA   = 5'b00100,
    SMP_PARITY = 5'b01000,
    SMP_STOP   = 5'b10000
  } smp_state_t;

endpackage

// File: rtl/rx_line_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to the idle
// (high) level so no spurious start edge is seen out of reset.
module rx_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic line
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[STAGES-2:0], rx};
  end

  assign line = sync_q[STAGES-1];

endmodule

// File: rtl/rx_bit_sampler.sv
// UART Rx front end: oversamples the synchronised line, 2-of-3 votes each bit
// centre and issues the mid-bit / end-of-bit strobes for the framing FSM.
module rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int SAMPLE_POINT = 8,
  parameter int DATA_BITS    = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  input  logic acq_sig_i,
  input  logic parity_enable_i,
  output logic rx_synch_o,
  output logic bit_synch_o,
  output logic bit_o,
  output logic frame_error_o,
  output logic false_start_o,
  output logic busy_o
);

  localparam int            CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_S0    = CW'(SAMPLE_POINT - 1);
  localparam logic [CW-1:0] CNT_S1    = CW'(SAMPLE_POINT);
  localparam logic [CW-1:0] CNT_VOTE  = CW'(SAMPLE_POINT + 1);
  localparam logic [3:0]    BITS_LAST = 4'(DATA_BITS);

  logic line;

  rx_line_sync #(.STAGES(SYNC_STAGES)) u_line_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx_i),
    .line (line)
  );

  // Triplicated control state, bitwise 2-of-3 voted on every read.
  logic [4:0]    state_q [3];
  logic [CW-1:0] cnt_q   [3];
  logic [3:0]    bcnt_q  [3];

  smp_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bcnt, bcnt_n, bcnt_inc;

  assign state = smp_state_t'((state_q[0] & state_q[1]) | (state_q[0] & state_q[2]) |
                              (state_q[1] & state_q[2]));
  assign cnt   = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
  assign bcnt  = (bcnt_q[0] & bcnt_q[1]) | (bcnt_q[0] & bcnt_q[2]) | (bcnt_q[1] & bcnt_q[2]);
  assign bcnt_inc = bcnt + 4'd1;

  logic prev_q, prev_n;
  logic samp0_q, samp0_n, samp1_q, samp1_n;
  logic par_q, par_n;
  logic bit_n, vote;
  logic rx_synch_n, bit_synch_n, fe_n, fs_n;

  assign vote = (samp0_q & samp1_q) | (samp0_q & line) | (samp1_q & line);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_n     = state;
    cnt_n       = cnt;
    bcnt_n      = bcnt;
    prev_n      = prev_q;
    samp0_n     = samp0_q;
    samp1_n     = samp1_q;
    par_n       = par_q;
    bit_n       = bit_o;
    rx_synch_n  = 1'b0;
    bit_synch_n = 1'b0;
    fe_n        = 1'b0;
    fs_n        = 1'b0;

    if (acq_sig_i) begin
      if (state == SMP_IDLE) begin
        prev_n = line;
        // Falling edge only: a line held low (break) cannot re-trigger.
        if (!line && prev_q) begin
          state_n = SMP_START;
          cnt_n   = '0;
        end
      end else begin
        cnt_n = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        if (cnt == CNT_S0) samp0_n = line;
        if (cnt == CNT_S1) samp1_n = line;

        if (cnt == CNT_VOTE) begin
          case (state)
            SMP_START: begin
              if (vote) begin
                fs_n    = 1'b1;
                state_n = SMP_IDLE;
                cnt_n   = '0;
              end else begin
                rx_synch_n = 1'b1;
                par_n      = parity_enable_i;
              end
            end
            SMP_DATA, SMP_PARITY: begin
              rx_synch_n = 1'b1;
              bit_n      = vote;
            end
            SMP_STOP: begin
              // Ending at mid-stop leaves half a bit of slack for the next start edge.
              bit_synch_n = 1'b1;
              bit_n       = vote;
              fe_n        = !vote;
              prev_n      = vote;
              state_n     = SMP_IDLE;
              cnt_n       = '0;
            end
            default: state_n = SMP_IDLE;
          endcase
        end

        if (cnt == CNT_LAST) begin
          bit_synch_n = 1'b1;
          case (state)
            SMP_START: begin
              state_n = SMP_DATA;
              bcnt_n  = '0;
            end
            SMP_DATA: begin
              bcnt_n = bcnt_inc;
              if (bcnt_inc == BITS_LAST)
                state_n = (par_q == ENABLE) ? SMP_PARITY : SMP_STOP;
            end
            SMP_PARITY: state_n = SMP_STOP;
            default:    state_n = SMP_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= SMP_IDLE;
        cnt_q[i]   <= '0;
        bcnt_q[i]  <= '0;
      end
      prev_q        <= 1'b1;
      samp0_q       <= 1'b0;
      samp1_q       <= 1'b0;
      par_q         <= DISABLE;
      bit_o         <= 1'b0;
      rx_synch_o    <= 1'b0;
      bit_synch_o   <= 1'b0;
      frame_error_o <= 1'b0;
      false_start_o <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_n;
        cnt_q[i]   <= cnt_n;
        bcnt_q[i]  <= bcnt_n;
      end
      prev_q        <= prev_n;
      samp0_q       <= samp0_n;
      samp1_q       <= samp1_n;
      par_q         <= par_n;
      bit_o         <= bit_n;
      rx_synch_o    <= rx_synch_n;
      bit_synch_o   <= bit_synch_n;
      frame_error_o <= fe_n;
      false_start_o <= fs_n;
    end
  end

  assign busy_o = (state != SMP_IDLE);

endmodule
